// File: rtl/if_pair_fetch_pkg.sv
// Shared definitions for the instruction pair fetch stage.
//   - NOP / LNOP filler encodings presented to decode when no real pair exists
//   - default local-store address width
//   - fetch FSM state encoding
package if_pair_fetch_pkg;

  localparam int          LS_AW_DEF = 18;
  localparam logic [31:0] NOP       = 32'h40200000;  // even-slot filler
  localparam logic [31:0] LNOP      = 32'h00200000;  // odd-slot filler

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_pair_fetch_fifo.sv
// Synchronous FIFO holding fetched instruction pairs plus their byte address.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, din        write one entry (caller guarantees not full)
//   pop, dout        consume head entry (caller guarantees not empty); dout is the head
//   clear            empties the FIFO; has priority over push and pop
//   count/empty/full occupancy
module if_pair_fifo
  import if_pair_fetch_pkg::*;
#(
  parameter int W     = 64 + LS_AW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/if_pair_fetch.sv
// Instruction fetch / issue buffer feeding the dual-issue decode stage.
// Issues 8-byte pair reads to local store, queues returned pairs, and presents one
// registered pair per cycle (out1 = word at pc, out2 = word at pc+4).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               hold the current output pair
//   flush, branch_target redirect fetch; all fetched/in-flight pairs are discarded
//   ls_req, ls_addr     local-store read request (8-byte aligned address)
//   ls_valid, ls_rdata  read response; [63:32] = word at addr, [31:0] = word at addr+4
//   instruction_out1/2  pair to decode; NOP/LNOP when pair_valid=0
//   pair_valid, pc_out  pair is real / byte address of the pair
//   dbg_state           current fetch FSM state
//
// Local-store handshake: the store is always ready, so a cycle with ls_req=1 is an
// accepted read of ls_addr. Its data returns with ls_valid=1 exactly LS_LAT cycles
// later, in request order. There is no back-pressure on responses; instead a request
// is only issued when the FIFO has room for every read still outstanding.
module if_pair_fetch
  import if_pair_fetch_pkg::*;
#(
  parameter int               LS_AW    = LS_AW_DEF,
  parameter int               DEPTH    = 4,
  parameter int               LS_LAT   = 2,
  parameter logic [LS_AW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [LS_AW-1:0] branch_target,
  output logic             ls_req,
  output logic [LS_AW-1:0] ls_addr,
  input  logic             ls_valid,
  input  logic [63:0]      ls_rdata,
  output logic [31:0]      instruction_out1,
  output logic [31:0]      instruction_out2,
  output logic             pair_valid,
  output logic [LS_AW-1:0] pc_out,
  output logic [1:0]       dbg_state
);

  localparam int FW = 64 + LS_AW;
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(LS_LAT+1);

  fetch_state_e     r_state;
  logic [LS_AW-1:0] r_fetch_pc;
  logic [LS_AW-1:0] r_resp_pc;     // address of the next response that will be kept
  logic [IW-1:0]    r_inflight;
  logic [IW-1:0]    r_drop;
  logic             r_odd_pending; // next kept pair starts at its odd word
  logic [31:0]      r_out1;
  logic [31:0]      r_out2;
  logic             r_pair_valid;
  logic [LS_AW-1:0] r_pc_out;

  logic [FW-1:0]    w_fifo_dout;
  logic [FW-1:0]    w_din;
  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic [31:0]      w_occ;
  logic             w_req;
  logic             w_accept;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_word0;
  logic [IW-1:0]    w_drop_next;
  logic [LS_AW-1:0] w_target_pc;

  assign w_occ  = 32'(w_count) + 32'(r_inflight);
  assign w_req  = (r_state != ST_START) && !flush && (w_occ < 32'(DEPTH));

  // A response is kept only when nothing is left to drop and no flush kills it.
  assign w_accept = ls_valid && (r_drop == '0) && !flush;
  // With an empty FIFO a kept response goes straight to the output register.
  assign w_bypass = w_accept && !stall && w_empty;
  assign w_push   = w_accept && !w_bypass;
  assign w_pop    = !stall && !flush && !w_empty;

  // After a redirect to an odd word the even slot of the first pair is not executed.
  assign w_word0     = r_odd_pending ? NOP : ls_rdata[63:32];
  assign w_din       = {w_word0, ls_rdata[31:0], r_resp_pc};
  assign w_drop_next = r_inflight - IW'(ls_valid);
  assign w_target_pc = {branch_target[LS_AW-1:3], 3'b000};

  if_pair_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (flush),
    .din   (w_din),
    .dout  (w_fifo_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_START;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_inflight    <= '0;
      r_drop        <= '0;
      r_odd_pending <= 1'b0;
      r_out1        <= NOP;
      r_out2        <= LNOP;
      r_pair_valid  <= 1'b0;
      r_pc_out      <= '0;
    end else begin
      case ({w_req, ls_valid})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (flush) begin
        r_fetch_pc    <= w_target_pc;
        r_resp_pc     <= w_target_pc;
        r_odd_pending <= branch_target[2];
        r_drop        <= w_drop_next;
        r_state       <= (w_drop_next != '0) ? ST_DRAIN : ST_RUN;
        r_out1        <= NOP;
        r_out2        <= LNOP;
        r_pair_valid  <= 1'b0;
        r_pc_out      <= '0;
      end else begin
        if (w_req) r_fetch_pc <= r_fetch_pc + LS_AW'(8);
        if (ls_valid && (r_drop != '0)) r_drop <= r_drop - IW'(1);
        if (w_accept) begin
          r_resp_pc     <= r_resp_pc + LS_AW'(8);
          r_odd_pending <= 1'b0;
        end

        case (r_state)
          ST_START: r_state <= ST_RUN;
          ST_DRAIN: begin
            if ((r_drop == '0) || ((r_drop == IW'(1)) && ls_valid)) r_state <= ST_RUN;
          end
          default:  r_state <= ST_RUN;
        endcase

        if (!stall) begin
          if (w_pop) begin
            r_out1       <= w_fifo_dout[FW-1 -: 32];
            r_out2       <= w_fifo_dout[FW-33 -: 32];
            r_pc_out     <= w_fifo_dout[LS_AW-1:0];
            r_pair_valid <= 1'b1;
          end else if (w_bypass) begin
            r_out1       <= w_din[FW-1 -: 32];
            r_out2       <= w_din[FW-33 -: 32];
            r_pc_out     <= w_din[LS_AW-1:0];
            r_pair_valid <= 1'b1;
          end else begin
            r_out1       <= NOP;
            r_out2       <= LNOP;
            r_pc_out     <= '0;
            r_pair_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign ls_req           = w_req;
  assign ls_addr          = r_fetch_pc;
  assign instruction_out1 = r_out1;
  assign instruction_out2 = r_out2;
  assign pair_valid       = r_pair_valid;
  assign pc_out           = r_pc_out;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_if_pair_fetch.sv
module tb_if_pair_fetch;
  import if_pair_fetch_pkg::*;

  localparam int AW  = 18;
  localparam int DEP = 4;
  localparam int LAT = 2;
  localparam int W   = AW + 64;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          ls_req;
  logic [AW-1:0] ls_addr;
  logic          ls_valid = 1'b0;
  logic [63:0]   ls_rdata = '0;
  logic [31:0]   instruction_out1;
  logic [31:0]   instruction_out2;
  logic          pair_valid;
  logic [AW-1:0] pc_out;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  if_pair_fetch #(
    .LS_AW    (AW),
    .DEPTH    (DEP),
    .LS_LAT   (LAT),
    .RESET_PC (18'h00000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .branch_target    (branch_target),
    .ls_req           (ls_req),
    .ls_addr          (ls_addr),
    .ls_valid         (ls_valid),
    .ls_rdata         (ls_rdata),
    .instruction_out1 (instruction_out1),
    .instruction_out2 (instruction_out2),
    .pair_valid       (pair_valid),
    .pc_out           (pc_out),
    .dbg_state        (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / LS model state ----------------
  logic [W-1:0]  exp_q[$];         // {pc, out1, out2}
  int            ls_due_q[$];
  logic [AW-1:0] ls_addr_q[$];
  int            cyc = 0;
  int            ref_cyc = 0;
  bit            first_pending = 1'b0;
  bit            chk_noreq = 1'b0;
  logic          prev_s = 1'b0;
  logic          prev_f = 1'b0;
  logic [AW-1:0] exp_req_pc = '0;
  logic [31:0]   h1, h2;
  logic          hv;
  logic [AW-1:0] hpc;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {14'h3000, a};
  endfunction

  // Expected pair stream after reset or a redirect to target.
  task automatic sb_restart(input logic [AW-1:0] target);
    logic [AW-1:0] pc;
    pc = {target[AW-1:3], 3'b000};
    exp_q.delete();
    exp_req_pc = pc;
    for (int k = 0; k < 48; k++) begin
      exp_q.push_back({pc, ((k == 0) && target[2]) ? NOP : mem_word(pc), mem_word(pc + AW'(4))});
      pc = pc + AW'(8);
    end
    first_pending = 1'b1;
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (prev_f) begin
      check_val("flush_pv", 64'(pair_valid), 64'(0));
      check_val("flush_out1", 64'(instruction_out1), 64'(NOP));
      check_val("flush_out2", 64'(instruction_out2), 64'(LNOP));
    end else if (prev_s) begin
      check_val("hold_out1", 64'(instruction_out1), 64'(h1));
      check_val("hold_out2", 64'(instruction_out2), 64'(h2));
      check_val("hold_pv", 64'(pair_valid), 64'(hv));
      check_val("hold_pc", 64'(pc_out), 64'(hpc));
    end else if (pair_valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_val("pc_out", 64'(pc_out), 64'(e[W-1 -: AW]));
        check_val("out1", 64'(instruction_out1), 64'(e[63:32]));
        check_val("out2", 64'(instruction_out2), 64'(e[31:0]));
        if (first_pending) begin
          check_val("first_pair_latency", 64'(cyc - ref_cyc), 64'(LAT + 2));
          first_pending = 1'b0;
        end
      end
    end
    h1  = instruction_out1;
    h2  = instruction_out2;
    hv  = pair_valid;
    hpc = pc_out;
  endtask

  // ---------------- driver: one clock cycle, entered and left at a negedge ----------------
  task automatic tick(input logic s, input logic f, input logic [AW-1:0] bt);
    check_outputs();
    stall = s;
    flush = f;
    branch_target = bt;
    if ((ls_due_q.size() > 0) && (ls_due_q[0] == cyc)) begin
      ls_valid = 1'b1;
      ls_rdata = {mem_word(ls_addr_q[0]), mem_word(ls_addr_q[0] + AW'(4))};
      void'(ls_due_q.pop_front());
      void'(ls_addr_q.pop_front());
    end else begin
      ls_valid = 1'b0;
      ls_rdata = '0;
    end
    #1;
    if (f) check_val("req_in_flush", 64'(ls_req), 64'(0));
    if (chk_noreq) check_val("req_when_full", 64'(ls_req), 64'(0));
    if (ls_req) begin
      check_val("ls_addr", 64'(ls_addr), 64'(exp_req_pc));
      exp_req_pc = exp_req_pc + AW'(8);
      ls_due_q.push_back(cyc + LAT);
      ls_addr_q.push_back(ls_addr);
    end
    if (f) begin
      sb_restart(bt);
      ref_cyc = cyc;
    end
    prev_s = s;
    prev_f = f;
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pv"}, 64'(pair_valid), 64'(0));
    check_val({tag, "_out1"}, 64'(instruction_out1), 64'(NOP));
    check_val({tag, "_out2"}, 64'(instruction_out2), 64'(LNOP));
    check_val({tag, "_pc"}, 64'(pc_out), 64'(0));
    check_val({tag, "_req"}, 64'(ls_req), 64'(0));
    check_val({tag, "_state"}, 64'(dbg_state), 64'(ST_START));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Test 1: fetch from reset, no stall.
    rst = 1'b0;
    sb_restart(18'h00000);
    ref_cyc = cyc;
    repeat (12) tick(1'b0, 1'b0, '0);
    check_val("t1_first_pair_seen", 64'(first_pending), 64'(0));

    // Test 2: five stalled cycles; by the last one the buffer is full.
    for (int i = 0; i < 5; i++) begin
      chk_noreq = (i == 4);
      tick(1'b1, 1'b0, '0);
    end
    chk_noreq = 1'b0;
    repeat (10) tick(1'b0, 1'b0, '0);

    // Test 3: flush with two reads outstanding.
    tick(1'b0, 1'b1, 18'h00100);
    check_val("t3_drain_state", 64'(dbg_state), 64'(ST_DRAIN));
    repeat (10) tick(1'b0, 1'b0, '0);
    check_val("t3_first_pair_seen", 64'(first_pending), 64'(0));

    // Test 4: flush and stall together, odd-word target.
    tick(1'b1, 1'b1, 18'h00104);
    repeat (10) tick(1'b0, 1'b0, '0);
    check_val("t4_first_pair_seen", 64'(first_pending), 64'(0));

    // Test 5: address wrap at the top of local store.
    tick(1'b0, 1'b1, 18'h3FFE8);
    repeat (12) tick(1'b0, 1'b0, '0);
    check_val("t5_first_pair_seen", 64'(first_pending), 64'(0));

    // Test 6: asynchronous reset while reads are outstanding, with random stall bursts before it.
    repeat (6) tick(1'(($urandom_range(0, 3) == 0)), 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    ls_due_q.delete();
    ls_addr_q.delete();
    ls_valid = 1'b0;
    ls_rdata = '0;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_s = 1'b0;
    prev_f = 1'b0;
    sb_restart(18'h00000);
    ref_cyc = cyc;
    repeat (12) tick(1'b0, 1'b0, '0);
    check_val("t6_first_pair_seen", 64'(first_pending), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
